// File: rtl/valid_ready_pipe.sv
// Valid/ready pipeline slice: STAGES register stages in series, each either a
// two-entry skid slice (SKID=1) or a one-entry forward slice (SKID=0).
module valid_ready_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int SKID   = 1,
    parameter int CW     = $clog2(2*STAGES+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] down_data,
    input  logic             down_valid,
    output logic             down_ready,
    output logic [WIDTH-1:0] up_data,
    output logic             up_valid,
    input  logic             up_ready,
    output logic [CW-1:0]    occupancy
);

    // Skid slice states, encoded by (main_v, skid_v):
    // state | meaning
    // EMPTY | main=0 skid=0, nothing held
    // ONE   | main=1 skid=0, one entry presented downstream
    // FULL  | main=1 skid=1, input stalled until main drains

    logic [WIDTH-1:0] st_data [0:STAGES];
    logic [STAGES:0]  st_valid;
    logic [STAGES:0]  st_ready;
    logic [CW-1:0]    occ_q;
    logic             down_fire;
    logic             up_fire;

    assign st_valid[0]      = down_valid;
    assign st_data[0]       = down_data;
    assign st_ready[STAGES] = up_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (SKID != 0) begin : g_skid
            logic             main_v;
            logic             skid_v;
            logic [WIDTH-1:0] main_d;
            logic [WIDTH-1:0] skid_d;
            logic             in_fire;
            logic             out_fire;

            assign st_ready[i]   = ~skid_v;
            assign in_fire       = st_valid[i] & ~skid_v;
            assign out_fire      = main_v & st_ready[i+1];
            assign st_valid[i+1] = main_v;
            assign st_data[i+1]  = main_d;

            always_ff @(posedge clk) begin
                if (reset) begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                    main_d <= '0;
                    skid_d <= '0;
                end else if (flush) begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end else if (skid_v) begin
                    if (out_fire) begin
                        main_d <= skid_d;
                        skid_v <= 1'b0;
                    end
                end else if (main_v) begin
                    if (in_fire && out_fire) begin
                        main_d <= st_data[i];
                    end else if (in_fire) begin
                        skid_d <= st_data[i];
                        skid_v <= 1'b1;
                    end else if (out_fire) begin
                        main_v <= 1'b0;
                    end
                end else if (in_fire) begin
                    main_v <= 1'b1;
                    main_d <= st_data[i];
                end
            end
        end else begin : g_fwd
            logic             v;
            logic [WIDTH-1:0] d;
            logic             in_fire;
            logic             out_fire;

            // Ready ripples combinationally from the consumer through every stage.
            assign st_ready[i]   = st_ready[i+1] | ~v;
            assign in_fire       = st_valid[i] & st_ready[i];
            assign out_fire      = v & st_ready[i+1];
            assign st_valid[i+1] = v;
            assign st_data[i+1]  = d;

            always_ff @(posedge clk) begin
                if (reset) begin
                    v <= 1'b0;
                    d <= '0;
                end else if (flush) begin
                    v <= 1'b0;
                end else if (in_fire) begin
                    v <= 1'b1;
                    d <= st_data[i];
                end else if (out_fire) begin
                    v <= 1'b0;
                end
            end
        end
    end

    assign down_ready = st_ready[0] & ~flush & ~reset;
    assign up_valid   = st_valid[STAGES] & ~flush & ~reset;
    assign up_data    = st_data[STAGES];
    assign down_fire  = down_valid & down_ready;
    assign up_fire    = up_valid & up_ready;
    assign occupancy  = occ_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ_q <= '0;
        end else if (down_fire && !up_fire) begin
            occ_q <= occ_q + CW'(1);
        end else if (up_fire && !down_fire) begin
            occ_q <= occ_q - CW'(1);
        end
    end

endmodule

// File: tb/tb_valid_ready_pipe.sv
// Bench for valid_ready_pipe: a skid pipe (STAGES=2) and a forward pipe (STAGES=3)
// checked against a FIFO scoreboard plus directed latency, fill, flush and reset cases.
module tb_valid_ready_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       s_flush, s_dv, s_dr, s_uv, s_ur;
    logic [7:0] s_dd, s_ud;
    logic [2:0] s_occ;

    logic       f_flush, f_dv, f_dr, f_uv, f_ur;
    logic [7:0] f_dd, f_ud;
    logic [2:0] f_occ;

    valid_ready_pipe #(.WIDTH(8), .STAGES(2), .SKID(1)) dut_skid (
        .clk(clk), .reset(reset), .flush(s_flush),
        .down_data(s_dd), .down_valid(s_dv), .down_ready(s_dr),
        .up_data(s_ud), .up_valid(s_uv), .up_ready(s_ur),
        .occupancy(s_occ)
    );

    valid_ready_pipe #(.WIDTH(8), .STAGES(3), .SKID(0)) dut_fwd (
        .clk(clk), .reset(reset), .flush(f_flush),
        .down_data(f_dd), .down_valid(f_dv), .down_ready(f_dr),
        .up_data(f_ud), .up_valid(f_uv), .up_ready(f_ur),
        .occupancy(f_occ)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: each pipe is an ordered FIFO of accepted words.
    logic [7:0] s_q[$];
    logic [7:0] f_q[$];
    int s_tx = 0, s_rx = 0, f_tx = 0, f_rx = 0;

    always @(negedge clk) begin
        if (reset) begin
            s_q.delete();
            f_q.delete();
        end else begin
            check_eq("s_occ", s_occ, s_q.size());
            check_eq("s_occ_cap", (s_occ <= 3'd4), 1);
            if (s_flush) begin
                check_eq("s_flush_dr", s_dr, 0);
                check_eq("s_flush_uv", s_uv, 0);
                s_q.delete();
            end else begin
                if (s_uv && s_ur) begin
                    if (s_q.size() == 0) check_eq("s_pop_empty", s_uv, 0);
                    else check_eq("s_data", s_ud, s_q.pop_front());
                    s_rx++;
                end
                if (s_dv && s_dr) begin
                    s_q.push_back(s_dd);
                    s_tx++;
                end
            end

            check_eq("f_occ", f_occ, f_q.size());
            check_eq("f_occ_cap", (f_occ <= 3'd3), 1);
            if (f_flush) begin
                check_eq("f_flush_dr", f_dr, 0);
                check_eq("f_flush_uv", f_uv, 0);
                f_q.delete();
            end else begin
                check_eq("f_ready", f_dr, f_ur | (f_q.size() < 3));
                if (f_uv && f_ur) begin
                    if (f_q.size() == 0) check_eq("f_pop_empty", f_uv, 0);
                    else check_eq("f_data", f_ud, f_q.pop_front());
                    f_rx++;
                end
                if (f_dv && f_dr) begin
                    f_q.push_back(f_dd);
                    f_tx++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drain_s();
        s_dv = 1'b0;
        s_ur = 1'b1;
        for (int c = 0; c < 40; c++) begin
            sample();
            if (s_q.size() == 0) break;
            step();
        end
        check_eq("s_drain", s_q.size(), 0);
        step();
    endtask

    task automatic drain_f();
        f_dv = 1'b0;
        f_ur = 1'b1;
        for (int c = 0; c < 40; c++) begin
            sample();
            if (f_q.size() == 0) break;
            step();
        end
        check_eq("f_drain", f_q.size(), 0);
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_tx, base_rx, found;

        reset = 1'b1;
        s_flush = 1'b0; s_dv = 1'b0; s_ur = 1'b0; s_dd = 8'h00;
        f_flush = 1'b0; f_dv = 1'b0; f_ur = 1'b0; f_dd = 8'h00;

        // Reset values
        step(); step();
        sample();
        check_eq("rst_s_uv", s_uv, 0);
        check_eq("rst_s_ud", s_ud, 0);
        check_eq("rst_s_occ", s_occ, 0);
        check_eq("rst_s_dr", s_dr, 0);
        check_eq("rst_f_uv", f_uv, 0);
        check_eq("rst_f_dr", f_dr, 0);
        step();
        reset = 1'b0;
        sample();
        check_eq("post_rst_s_dr", s_dr, 1);
        check_eq("post_rst_f_dr", f_dr, 1);
        step();

        // Streaming 0x01..0x10, latency and steady occupancy
        base_rx = s_rx;
        s_ur = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            s_dv = 1'b1;
            s_dd = 8'(k);
            sample();
            check_eq("stream_dr", s_dr, 1);
            if (k <= 2) check_eq("stream_lat_uv", s_uv, 0);
            if (k == 3) begin
                check_eq("stream_first_uv", s_uv, 1);
                check_eq("stream_first_ud", s_ud, 8'h01);
            end
            if (k >= 3) check_eq("stream_occ", s_occ, 2);
            step();
        end
        drain_s();
        check_eq("stream_count", s_rx - base_rx, 16);

        // Backpressure fill: exactly four accepted, then resume
        base_tx = s_tx;
        base_rx = s_rx;
        s_ur = 1'b0;
        for (int c = 0; c < 8; c++) begin
            s_dv = 1'b1;
            s_dd = 8'(8'h40 + (s_tx - base_tx));
            sample();
            step();
        end
        sample();
        check_eq("fill_accepted", s_tx - base_tx, 4);
        check_eq("fill_dr", s_dr, 0);
        check_eq("fill_occ", s_occ, 4);
        step();
        s_ur = 1'b1;
        for (int c = 0; c < 20; c++) begin
            s_dv = 1'b1;
            s_dd = 8'(8'h40 + (s_tx - base_tx));
            sample();
            step();
        end
        drain_s();
        check_eq("fill_all_out", s_rx - base_rx, s_tx - base_tx);

        // Random ready/valid, skid pipe
        base_tx = s_tx;
        base_rx = s_rx;
        for (int c = 0; c < 20000 && (s_rx - base_rx) < 1000; c++) begin
            s_ur = 1'($urandom_range(0, 1));
            s_dv = (s_tx - base_tx < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_dd = 8'($urandom);
            sample();
            step();
        end
        check_eq("s_rand_count", s_rx - base_rx, 1000);
        drain_s();

        // Random ready/valid, forward pipe
        base_tx = f_tx;
        base_rx = f_rx;
        for (int c = 0; c < 20000 && (f_rx - base_rx) < 1000; c++) begin
            f_ur = 1'($urandom_range(0, 1));
            f_dv = (f_tx - base_tx < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            f_dd = 8'($urandom);
            sample();
            step();
        end
        check_eq("f_rand_count", f_rx - base_rx, 1000);
        drain_f();

        // Forward pipe full passthrough
        f_ur = 1'b0;
        for (int c = 0; c < 10; c++) begin
            f_dv = 1'b1;
            f_dd = 8'($urandom);
            sample();
            step();
        end
        sample();
        check_eq("f_full_occ", f_occ, 3);
        check_eq("f_full_dr", f_dr, 0);
        step();
        f_ur = 1'b1;
        for (int c = 0; c < 5; c++) begin
            f_dv = 1'b1;
            f_dd = 8'($urandom);
            sample();
            check_eq("f_pass_dr", f_dr, 1);
            check_eq("f_pass_occ", f_occ, 3);
            step();
        end
        drain_f();

        // Flush mid-stall on the skid pipe
        s_ur = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_dv = 1'b1;
            s_dd = 8'(8'h10 + k);
            sample();
            check_eq("flush_fill_dr", s_dr, 1);
            step();
        end
        s_dv = 1'b1;
        s_dd = 8'h77;
        s_flush = 1'b1;
        sample();
        check_eq("flush_dr", s_dr, 0);
        check_eq("flush_uv", s_uv, 0);
        step();
        s_flush = 1'b0;
        s_dv = 1'b0;
        sample();
        check_eq("post_flush_uv", s_uv, 0);
        check_eq("post_flush_occ", s_occ, 0);
        check_eq("post_flush_dr", s_dr, 1);
        step();
        s_ur = 1'b1;
        s_dv = 1'b1;
        s_dd = 8'hA5;
        sample();
        step();
        s_dv = 1'b0;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (s_uv) begin
                found = 1;
                break;
            end
            step();
        end
        check_eq("flush_next_valid", found, 1);
        check_eq("flush_next_data", s_ud, 8'hA5);
        step();
        drain_s();

        // Reset while the skid pipe holds four words
        s_ur = 1'b0;
        for (int c = 0; c < 6; c++) begin
            s_dv = 1'b1;
            s_dd = 8'($urandom_range(1, 255));
            sample();
            step();
        end
        sample();
        check_eq("prerst_occ", s_occ, 4);
        step();
        reset = 1'b1;
        sample();
        check_eq("midrst_uv", s_uv, 0);
        check_eq("midrst_dr", s_dr, 0);
        step();
        sample();
        check_eq("midrst_ud", s_ud, 0);
        check_eq("midrst_occ", s_occ, 0);
        check_eq("midrst_uv2", s_uv, 0);
        check_eq("midrst_dr2", s_dr, 0);
        step();
        reset = 1'b0;
        s_dv = 1'b0;
        sample();
        check_eq("afterrst_dr", s_dr, 1);
        check_eq("afterrst_occ", s_occ, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
